multicycle_control: RTL
=======================

// Module: multicycle_control
// PURPOSE
//  Main control FSM for the multicycle MIPS datapath. Issues the ALU-op code consumed by the ALU control decoder
//  (000 = R-type/use funct, 010 add, 110 sub, 111 slt, 011 and, 001 or) plus all datapath enables, one state per cycle.
//  Sits between instruction register opcode and datapath; handshakes with unified memory via mem_ready.
// PARAMETERS
//  OP_W     6  opcode width
//  ALUOP_W  3  ALU-op code width (matches ALU control input)
// PORTS
//  clk          in   1        rising-edge clock, single domain
//  rst_n        in   1        asynchronous, active-low reset
//  opcode       in   OP_W     instruction[31:26] from IR
//  zero         in   1        ALU zero flag (informational; branch gating done in datapath via pc_write_cond)
//  mem_ready    in   1        memory completes current read/write this cycle
//  pc_write     out  1        unconditional PC load
//  pc_write_cond out 1        PC load if zero
//  i_or_d       out  1        0 = PC addresses memory, 1 = ALUOut
//  mem_read     out  1        memory read request
//  mem_write    out  1        memory write request
//  ir_write     out  1        IR load
//  mem_to_reg   out  1        0 = ALUOut, 1 = MDR to register file
//  reg_dst      out  1        0 = rt, 1 = rd
//  reg_write    out  1        register file write
//  alu_src_a    out  1        0 = PC, 1 = rs
//  alu_src_b    out  2        00 rt, 01 const 4, 10 sign-ext imm, 11 imm<<2
//  pc_source    out  2        00 ALU, 01 ALUOut, 10 jump target
//  alu_op       out  ALUOP_W  code to ALU control
//  state_o      out  4        current state (debug)
//  illegal_op   out  1        sticky illegal-opcode flag
// BEHAVIOUR
//  Moore outputs decoded from registered state, except handshake-gated enables noted below.
//  rst_n low: state=RST (0), all outputs 0, illegal_op=0; mid-instruction reset aborts immediately, no write completes.
//  RST(0) -> FETCH next edge; outputs all 0.
//  FETCH(1): mem_read, alu_src_b=01, alu_op=010; ir_write and pc_write asserted only in cycle mem_ready=1; stay until mem_ready.
//  DECODE(2): alu_src_b=11, alu_op=010. Branch on opcode: 000000->R_EXEC, 100011/101011->MEM_ADDR, 000100->BRANCH,
//    000010->JUMP, 001000/001100/001101/001010->I_EXEC, other->illegal handling (see CONFIGURATION).
//  MEM_ADDR(3): alu_src_a=1, alu_src_b=10, alu_op=010; lw->MEM_RD, sw->MEM_WR.
//  MEM_RD(4): mem_read, i_or_d=1; hold until mem_ready, then MEM_WB.   MEM_WB(5): reg_write, mem_to_reg=1 -> FETCH.
//  MEM_WR(6): mem_write, i_or_d=1; hold until mem_ready, then FETCH.
//  R_EXEC(7): alu_src_a=1, alu_src_b=00, alu_op=000 -> R_WB(8): reg_write, reg_dst=1 -> FETCH.
//  BRANCH(9): alu_src_a=1, alu_op=110, pc_write_cond, pc_source=01 -> FETCH.  JUMP(10): pc_write, pc_source=10 -> FETCH.
//  I_EXEC(11): alu_src_a=1, alu_src_b=10, alu_op = addi 010 / andi 011 / ori 001 / slti 111; opcode
//    is latched in DECODE so IR changes cannot alter it -> I_WB(12): reg_write, reg_dst=0 -> FETCH.
//  Latency with mem_ready tied 1: j/beq 3, R/I/sw 4, lw 5 cycles; each wait cycle adds exactly one.
//  mem_read/mem_write stay asserted and address-stable while waiting; never both high.
//  Unused state encodings (14,15) -> FETCH next edge, outputs 0.
// CONFIGURATION
//  MC_ILLEGAL_TRAP_EN defined: illegal opcode in DECODE -> TRAP(13); illegal_op=1 sticky, all enables 0, remain
//    until rst_n. Undefined: illegal opcode -> FETCH (treated as nop, PC already advanced); illegal_op tied 0.
// STRUCTURE
//  Package mc_pkg: state encodings, opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI, OP_ANDI,
//    OP_ORI, OP_SLTI), ALU-op constants (ALUOP_FUNCT, ALUOP_ADD, ALUOP_SUB, ALUOP_SLT, ALUOP_AND, ALUOP_OR).
//  Sub-module mc_imm_aluop: combinational latched-opcode -> I-type alu_op map. Remainder in one FSM module.
// TESTING
//  Reset: rst_n=0 mid MEM_WR -> same cycle mem_write=0, state_o=0; release -> FETCH next edge.
//  add (op 000000), mem_ready=1 -> states 1,2,7,8,1; alu_op 010,010,000,-; reg_write+reg_dst=1 in state 8 only.
//  lw (100011), mem_ready low 2 cycles in MEM_RD -> states 1,2,3,4,4,4,5,1; mem_read held 3 cycles, i_or_d=1.
//  beq (000100) -> 1,2,9,1; alu_op=110, pc_write_cond=1, pc_source=01 in state 9; ori (001101) -> alu_op=001 in 11.
//  FETCH with mem_ready=0 4 cycles -> ir_write/pc_write stay 0, asserted only on the ready cycle.
//  opcode 111111: with MC_ILLEGAL_TRAP_EN -> state 13, illegal_op=1 until reset; without -> back to 1, illegal_op=0.

Source files
------------

// File: rtl/mc_pkg.sv
// +-----------------------------------------------------------------------------+
// | mc_pkg : states, opcodes, ALU-op codes and control word for multicycle_control |
// | Rev 1.0                                                                     |
// +-----------------------------------------------------------------------------+
`default_nettype none

package mc_pkg;

  typedef enum logic [3:0] {
    S_RST      = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_MEM_ADDR = 4'd3,
    S_MEM_RD   = 4'd4,
    S_MEM_WB   = 4'd5,
    S_MEM_WR   = 4'd6,
    S_R_EXEC   = 4'd7,
    S_R_WB     = 4'd8,
    S_BRANCH   = 4'd9,
    S_JUMP     = 4'd10,
    S_I_EXEC   = 4'd11,
    S_I_WB     = 4'd12,
    S_TRAP     = 4'd13
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_SLTI  = 6'b001010;

  localparam logic [2:0] ALUOP_FUNCT = 3'b000;
  localparam logic [2:0] ALUOP_ADD   = 3'b010;
  localparam logic [2:0] ALUOP_SUB   = 3'b110;
  localparam logic [2:0] ALUOP_SLT   = 3'b111;
  localparam logic [2:0] ALUOP_AND   = 3'b011;
  localparam logic [2:0] ALUOP_OR    = 3'b001;

  localparam logic [1:0] SRCB_RT    = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_source;
    logic [2:0] alu_op;
  } ctrl_t;

  function automatic logic is_itype(input logic [5:0] op);
    return (op == OP_ADDI) || (op == OP_ANDI) || (op == OP_ORI) || (op == OP_SLTI);
  endfunction

endpackage

`default_nettype wire

// File: rtl/mc_imm_aluop.sv
// +-----------------------------------------------------------------------------+
// | mc_imm_aluop : maps a latched I-type opcode to the ALU-op code              |
// | Rev 1.0                                                                     |
// +-----------------------------------------------------------------------------+
`default_nettype none

module mc_imm_aluop
  import mc_pkg::*;
#(
  parameter int OP_W    = 6,
  parameter int ALUOP_W = 3
) (
  input  logic [OP_W-1:0]    op,
  output logic [ALUOP_W-1:0] alu_op
);

  always_comb begin
    alu_op = ALUOP_ADD;
    case (op)
      OP_ADDI: alu_op = ALUOP_ADD;
      OP_ANDI: alu_op = ALUOP_AND;
      OP_ORI:  alu_op = ALUOP_OR;
      OP_SLTI: alu_op = ALUOP_SLT;
      default: alu_op = ALUOP_ADD;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/multicycle_control.sv
// +-----------------------------------------------------------------------------+
// | multicycle_control : main control FSM of the multicycle MIPS datapath       |
// | Optional illegal-opcode trap: define MC_ILLEGAL_TRAP_EN                     |
// | Rev 1.0                                                                     |
// +-----------------------------------------------------------------------------+
`default_nettype none

module multicycle_control
  import mc_pkg::*;
#(
  parameter int OP_W    = 6,
  parameter int ALUOP_W = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [OP_W-1:0]    opcode,
  input  logic               zero,
  input  logic               mem_ready,
  output logic               pc_write,
  output logic               pc_write_cond,
  output logic               i_or_d,
  output logic               mem_read,
  output logic               mem_write,
  output logic               ir_write,
  output logic               mem_to_reg,
  output logic               reg_dst,
  output logic               reg_write,
  output logic               alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [1:0]         pc_source,
  output logic [ALUOP_W-1:0] alu_op,
  output logic [3:0]         state_o,
  output logic               illegal_op
);

  state_t             state;
  state_t             state_nxt;
  logic [OP_W-1:0]    op_q;
  logic [ALUOP_W-1:0] imm_aluop;
  ctrl_t              ctrl;
  logic               unused_zero;

  // Branch resolution happens in the datapath through pc_write_cond.
  assign unused_zero = zero;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_RST;
    end else begin
      state <= state_nxt;
    end
  end

  // The IR may be reloaded later, so later states use this copy only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q <= '0;
    end else if (state == S_DECODE) begin
      op_q <= opcode;
    end
  end

  mc_imm_aluop #(
    .OP_W    (OP_W),
    .ALUOP_W (ALUOP_W)
  ) u_imm_aluop (
    .op     (op_q),
    .alu_op (imm_aluop)
  );

  always_comb begin
    state_nxt = S_FETCH;
    case (state)
      S_RST:    state_nxt = S_FETCH;
      S_FETCH:  state_nxt = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        if (opcode == OP_RTYPE) begin
          state_nxt = S_R_EXEC;
        end else if ((opcode == OP_LW) || (opcode == OP_SW)) begin
          state_nxt = S_MEM_ADDR;
        end else if (opcode == OP_BEQ) begin
          state_nxt = S_BRANCH;
        end else if (opcode == OP_J) begin
          state_nxt = S_JUMP;
        end else if (is_itype(opcode)) begin
          state_nxt = S_I_EXEC;
        end else begin
`ifdef MC_ILLEGAL_TRAP_EN
          state_nxt = S_TRAP;
`else
          state_nxt = S_FETCH;
`endif
        end
      end
      S_MEM_ADDR: state_nxt = (op_q == OP_LW) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD:   state_nxt = mem_ready ? S_MEM_WB : S_MEM_RD;
      S_MEM_WB:   state_nxt = S_FETCH;
      S_MEM_WR:   state_nxt = mem_ready ? S_FETCH : S_MEM_WR;
      S_R_EXEC:   state_nxt = S_R_WB;
      S_R_WB:     state_nxt = S_FETCH;
      S_BRANCH:   state_nxt = S_FETCH;
      S_JUMP:     state_nxt = S_FETCH;
      S_I_EXEC:   state_nxt = S_I_WB;
      S_I_WB:     state_nxt = S_FETCH;
`ifdef MC_ILLEGAL_TRAP_EN
      S_TRAP:     state_nxt = S_TRAP;
`else
      S_TRAP:     state_nxt = S_FETCH;
`endif
      default:    state_nxt = S_FETCH;
    endcase
  end

  always_comb begin
    ctrl = '0;
    case (state)
      S_FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_b = SRCB_FOUR;
        ctrl.alu_op    = ALUOP_ADD;
        ctrl.ir_write  = mem_ready;
        ctrl.pc_write  = mem_ready;
      end
      S_DECODE: begin
        ctrl.alu_src_b = SRCB_IMMSH;
        ctrl.alu_op    = ALUOP_ADD;
      end
      S_MEM_ADDR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALUOP_ADD;
      end
      S_MEM_RD: begin
        ctrl.mem_read = 1'b1;
        ctrl.i_or_d   = 1'b1;
      end
      S_MEM_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
      end
      S_MEM_WR: begin
        ctrl.mem_write = 1'b1;
        ctrl.i_or_d    = 1'b1;
      end
      S_R_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_RT;
        ctrl.alu_op    = ALUOP_FUNCT;
      end
      S_R_WB: begin
        ctrl.reg_write = 1'b1;
        ctrl.reg_dst   = 1'b1;
      end
      S_BRANCH: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_src_b     = SRCB_RT;
        ctrl.alu_op        = ALUOP_SUB;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_source     = PCSRC_ALUOUT;
      end
      S_JUMP: begin
        ctrl.pc_write  = 1'b1;
        ctrl.pc_source = PCSRC_JUMP;
      end
      S_I_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = imm_aluop;
      end
      S_I_WB: begin
        ctrl.reg_write = 1'b1;
        ctrl.reg_dst   = 1'b0;
      end
      default: ctrl = '0;
    endcase
  end

`ifdef MC_ILLEGAL_TRAP_EN
  logic illegal_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      illegal_q <= 1'b0;
    end else if ((state == S_DECODE) && (state_nxt == S_TRAP)) begin
      illegal_q <= 1'b1;
    end
  end

  assign illegal_op = illegal_q;
`else
  assign illegal_op = 1'b0;
`endif

  assign pc_write      = ctrl.pc_write;
  assign pc_write_cond = ctrl.pc_write_cond;
  assign i_or_d        = ctrl.i_or_d;
  assign mem_read      = ctrl.mem_read;
  assign mem_write     = ctrl.mem_write;
  assign ir_write      = ctrl.ir_write;
  assign mem_to_reg    = ctrl.mem_to_reg;
  assign reg_dst       = ctrl.reg_dst;
  assign reg_write     = ctrl.reg_write;
  assign alu_src_a     = ctrl.alu_src_a;
  assign alu_src_b     = ctrl.alu_src_b;
  assign pc_source     = ctrl.pc_source;
  assign alu_op        = ctrl.alu_op;
  assign state_o       = state;

endmodule

`default_nettype wire
